// File: rtl/audio_pkg.sv
// Shared types and I2S frame constants for the audio output path.
package audio_pkg;

   localparam int unsigned CH_BITS    = 16;
   localparam int unsigned SLOTS      = 32;
   localparam int unsigned FRAME_BITS = 2 * CH_BITS;
   localparam int unsigned SLOT_W     = $clog2(SLOTS);

   typedef enum logic {
      IDLE = 1'b0,
      RUN  = 1'b1
   } tx_state_e;

   typedef struct packed {
      logic [CH_BITS-1:0] left;
      logic [CH_BITS-1:0] right;
   } stereo_sample_t;

endpackage

// File: rtl/sample_fifo.sv
// Synchronous FIFO with registered full/empty flags and occupancy level.
module sample_fifo #(
   parameter  int unsigned WIDTH = 32,
   parameter  int unsigned DEPTH = 4,
   localparam int unsigned AW    = $clog2(DEPTH),
   localparam int unsigned LW    = AW + 1
) (
   input  logic             clock,
   input  logic             reset_n,
   input  logic             push,
   input  logic [WIDTH-1:0] wdata,
   input  logic             pop,
   output logic [WIDTH-1:0] rdata,
   output logic             full,
   output logic             empty,
   output logic [LW-1:0]    level
);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic             push_ok_c;
   logic             pop_ok_c;
   logic [LW-1:0]    level_nxt_c;

   // A full FIFO refuses a push even when a pop happens in the same cycle.
   always_comb begin
      push_ok_c   = push && !full;
      pop_ok_c    = pop && !empty;
      level_nxt_c = level;
      if (push_ok_c && !pop_ok_c)
         level_nxt_c = level + LW'(1);
      else if (!push_ok_c && pop_ok_c)
         level_nxt_c = level - LW'(1);
   end

   assign rdata = mem[rd_ptr];

   always_ff @(posedge clock) begin
      if (push_ok_c)
         mem[wr_ptr] <= wdata;
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         level  <= '0;
         full   <= 1'b0;
         empty  <= 1'b1;
      end else begin
         if (push_ok_c)
            wr_ptr <= wr_ptr + AW'(1);
         if (pop_ok_c)
            rd_ptr <= rd_ptr + AW'(1);
         level <= level_nxt_c;
         full  <= (level_nxt_c == LW'(DEPTH));
         empty <= (level_nxt_c == '0);
      end
   end

endmodule

// File: rtl/i2s_transmitter.sv
// Philips I2S serialiser for 16-bit stereo PCM with internal BCLK/LRCLK generation.
module i2s_transmitter
   import audio_pkg::*;
#(
   parameter  int unsigned BCLK_HALF  = 16,
   parameter  int unsigned FIFO_DEPTH = 4,
   localparam int unsigned LVL_W      = $clog2(FIFO_DEPTH) + 1
) (
   input  logic               clock,
   input  logic               reset_n,
   input  logic               enable,
   input  logic               sample_valid,
   output logic               sample_ready,
   input  logic [CH_BITS-1:0] sample_left,
   input  logic [CH_BITS-1:0] sample_right,
   output logic               bclk,
   output logic               lrclk,
   output logic               dacdat,
   output logic [LVL_W-1:0]   fifo_level,
   output logic [15:0]        underflow_count
);

   localparam int unsigned     DIV_W    = $clog2(BCLK_HALF);
   localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(BCLK_HALF - 1);

   tx_state_e             state;
   logic [DIV_W-1:0]      div;
   logic [SLOT_W-1:0]     slot;
   logic [FRAME_BITS-1:0] sr;

   stereo_sample_t        push_word;
   stereo_sample_t        head_word;
   logic                  fifo_full;
   logic                  fifo_empty;

   logic                  div_wrap_c;
   logic                  bclk_fall_c;
   logic                  frame_start_c;
   logic                  pop_c;
   logic [SLOT_W-1:0]     slot_nxt_c;
   logic [FRAME_BITS-1:0] load_word_c;

   assign push_word    = '{left: sample_left, right: sample_right};
   assign sample_ready = !fifo_full;

   // Frame start is the falling edge that leaves slot 0; the head is popped there.
   always_comb begin
      div_wrap_c    = (state == RUN) && (div == DIV_LAST);
      bclk_fall_c   = div_wrap_c && bclk;
      frame_start_c = bclk_fall_c && (slot == '0);
      pop_c         = frame_start_c && enable && !fifo_empty;
      slot_nxt_c    = slot + SLOT_W'(1);
      load_word_c   = fifo_empty ? '0 : FRAME_BITS'(head_word);
   end

   sample_fifo #(
      .WIDTH (FRAME_BITS),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clock   (clock),
      .reset_n (reset_n),
      .push    (sample_valid),
      .wdata   (push_word),
      .pop     (pop_c),
      .rdata   (head_word),
      .full    (fifo_full),
      .empty   (fifo_empty),
      .level   (fifo_level)
   );

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state           <= IDLE;
         div             <= '0;
         slot            <= '0;
         sr              <= '0;
         bclk            <= 1'b0;
         lrclk           <= 1'b0;
         dacdat          <= 1'b0;
         underflow_count <= '0;
      end else begin
         unique case (state)
            IDLE: begin
               div    <= '0;
               slot   <= '0;
               sr     <= '0;
               bclk   <= 1'b0;
               lrclk  <= 1'b0;
               dacdat <= 1'b0;
               if (enable)
                  state <= RUN;
            end
            RUN: begin
               if (div_wrap_c) begin
                  div <= '0;
                  if (!bclk) begin
                     bclk <= 1'b1;
                  end else if (frame_start_c && !enable) begin
                     // Stop only on a frame boundary so right[0] is never truncated.
                     state  <= IDLE;
                     bclk   <= 1'b0;
                     lrclk  <= 1'b0;
                     dacdat <= 1'b0;
                     slot   <= '0;
                     sr     <= '0;
                  end else begin
                     bclk  <= 1'b0;
                     slot  <= slot_nxt_c;
                     lrclk <= slot_nxt_c[SLOT_W-1];
                     if (frame_start_c) begin
                        dacdat <= load_word_c[FRAME_BITS-1];
                        sr     <= {load_word_c[FRAME_BITS-2:0], 1'b0};
                        if (fifo_empty && (underflow_count != 16'hFFFF))
                           underflow_count <= underflow_count + 16'd1;
                     end else begin
                        dacdat <= sr[FRAME_BITS-1];
                        sr     <= {sr[FRAME_BITS-2:0], 1'b0};
                     end
                  end
               end else begin
                  div <= div + DIV_W'(1);
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_i2s_transmitter.sv
// Self-checking bench: queue-based sample model and a behavioural I2S receiver.
module tb_i2s_transmitter;

   localparam int unsigned H     = 2;
   localparam int unsigned DEPTH = 4;
   localparam int unsigned SLOTC = 2 * H;
   localparam int unsigned FRAME = 32 * SLOTC;

   logic        clock = 1'b0;
   logic        reset_n;
   logic        enable;
   logic        sample_valid;
   logic        sample_ready;
   logic [15:0] sample_left;
   logic [15:0] sample_right;
   logic        bclk;
   logic        lrclk;
   logic        dacdat;
   logic [2:0]  fifo_level;
   logic [15:0] underflow_count;

   int          checks = 0;
   int          errors = 0;
   int          rel = 0;
   int          rx_base = 0;
   logic [15:0] exp_uf = '0;
   logic [31:0] model_q[$];
   logic [31:0] exp_rx[$];

   // Receiver side: frames decoded by watching word-select transitions.
   logic [31:0] rx_q[$];
   logic [15:0] rx_acc = '0;
   logic [15:0] rx_left = '0;
   logic        rx_prev_lr = 1'b0;

   i2s_transmitter #(.BCLK_HALF(H), .FIFO_DEPTH(DEPTH)) dut (
      .clock           (clock),
      .reset_n         (reset_n),
      .enable          (enable),
      .sample_valid    (sample_valid),
      .sample_ready    (sample_ready),
      .sample_left     (sample_left),
      .sample_right    (sample_right),
      .bclk            (bclk),
      .lrclk           (lrclk),
      .dacdat          (dacdat),
      .fifo_level      (fifo_level),
      .underflow_count (underflow_count)
   );

   always #5 clock = ~clock;

   // Philips format: the bit sampled when WS changes is the LSB of the previous word.
   always @(posedge bclk or negedge reset_n) begin
      if (!reset_n) begin
         rx_prev_lr = 1'b0;
         rx_acc     = '0;
      end else begin
         if (lrclk != rx_prev_lr) begin
            if (!rx_prev_lr)
               rx_left = {rx_acc[14:0], dacdat};
            else
               rx_q.push_back({rx_left, rx_acc[14:0], dacdat});
            rx_acc = '0;
         end else begin
            rx_acc = {rx_acc[14:0], dacdat};
         end
         rx_prev_lr = lrclk;
      end
   end

   task automatic tick();
      @(posedge clock);
      #1;
      rel++;
   endtask

   task automatic tick_to(input int target);
      while (rel < target) tick();
   endtask

   task automatic begin_capture();
      rel     = 0;
      rx_base = rx_q.size();
      exp_rx.delete();
   endtask

   task automatic start_run();
      enable = 1'b1;
      tick();
      begin_capture();
   endtask

   task automatic push_burst(input int n);
      for (int k = 0; k < n; k++) begin
         logic [31:0] w;
         w            = $urandom;
         sample_left  = w[31:16];
         sample_right = w[15:0];
         sample_valid = 1'b1;
         tick();
         if (model_q.size() < DEPTH) model_q.push_back(w);
         checks++;
         if (fifo_level !== 3'(model_q.size()) || sample_ready !== (model_q.size() < DEPTH)) begin
            errors++;
            $display("FAIL push_burst[%0d]: level=%0d ready=%b, expected level=%0d ready=%b",
                     k, fifo_level, sample_ready, model_q.size(), (model_q.size() < DEPTH));
         end
      end
      sample_valid = 1'b0;
   endtask

   // Streams nf frames from the run entry edge; optionally drops enable at slot 10 of the last one.
   task automatic run_frames(input int nf, input bit do_stop);
      tick_to(1);
      checks++;
      if (bclk !== 1'b0) begin errors++; $display("FAIL bclk_early: got %b expected 0", bclk); end
      tick_to(2);
      checks++;
      if (bclk !== 1'b1) begin errors++; $display("FAIL bclk_first_rise: got %b expected 1", bclk); end
      for (int f = 0; f < nf; f++) begin
         logic [31:0] fr;
         tick_to(FRAME * f + SLOTC - 1);
         checks++;
         if (fifo_level !== 3'(model_q.size())) begin
            errors++;
            $display("FAIL pre_pop_level[%0d]: got %0d expected %0d", f, fifo_level, model_q.size());
         end
         tick_to(FRAME * f + SLOTC);
         if (model_q.size() > 0) fr = model_q.pop_front();
         else begin
            fr = '0;
            if (exp_uf != 16'hFFFF) exp_uf++;
         end
         exp_rx.push_back(fr);
         checks++;
         if (fifo_level !== 3'(model_q.size()) || dacdat !== fr[31] || lrclk !== 1'b0 ||
             underflow_count !== exp_uf) begin
            errors++;
            $display("FAIL frame_start[%0d]: level=%0d dacdat=%b lrclk=%b uf=%h, expected %0d %b 0 %h",
                     f, fifo_level, dacdat, lrclk, underflow_count, model_q.size(), fr[31], exp_uf);
         end
      end
      if (do_stop) begin
         tick_to(FRAME * (nf - 1) + 10 * SLOTC);
         enable = 1'b0;
         tick_to(FRAME * nf + SLOTC - 1);
         checks++;
         if (bclk !== 1'b1 || lrclk !== 1'b0 || dacdat !== exp_rx[nf-1][0]) begin
            errors++;
            $display("FAIL last_lsb_slot: bclk=%b lrclk=%b dacdat=%b, expected 1 0 %b",
                     bclk, lrclk, dacdat, exp_rx[nf-1][0]);
         end
         tick_to(FRAME * nf + SLOTC);
         checks++;
         if (bclk !== 1'b0 || lrclk !== 1'b0 || dacdat !== 1'b0 || fifo_level !== 3'(model_q.size())) begin
            errors++;
            $display("FAIL stop_edge: bclk=%b lrclk=%b dacdat=%b level=%0d, expected 0 0 0 %0d",
                     bclk, lrclk, dacdat, fifo_level, model_q.size());
         end
         tick_to(FRAME * nf + SLOTC + 8);
         checks++;
         if (bclk !== 1'b0 || fifo_level !== 3'(model_q.size())) begin
            errors++;
            $display("FAIL idle_hold: bclk=%b level=%0d, expected 0 %0d", bclk, fifo_level, model_q.size());
         end
         checks++;
         if (rx_q.size() - rx_base != nf) begin
            errors++;
            $display("FAIL rx_count: got %0d expected %0d", rx_q.size() - rx_base, nf);
         end else begin
            for (int f = 0; f < nf; f++) begin
               checks++;
               if (rx_q[rx_base+f] !== exp_rx[f]) begin
                  errors++;
                  $display("FAIL rx_frame[%0d]: got %h expected %h", f, rx_q[rx_base+f], exp_rx[f]);
               end
            end
         end
      end
   endtask

   task automatic test_reset();
      reset_n = 1'b0; enable = 1'b0; sample_valid = 1'b0;
      sample_left = '0; sample_right = '0;
      repeat (3) tick();
      checks++;
      if (bclk !== 1'b0 || lrclk !== 1'b0 || dacdat !== 1'b0 || sample_ready !== 1'b1 ||
          fifo_level !== 3'd0 || underflow_count !== 16'd0) begin
         errors++;
         $display("FAIL reset_values: bclk=%b lrclk=%b dacdat=%b ready=%b level=%0d uf=%h",
                  bclk, lrclk, dacdat, sample_ready, fifo_level, underflow_count);
      end
      reset_n = 1'b1;
      tick();
   endtask

   task automatic test_single_frame();
      sample_left = 16'h1234; sample_right = 16'hABCD; sample_valid = 1'b1;
      tick();
      sample_valid = 1'b0;
      model_q.push_back(32'h1234ABCD);
      checks++;
      if (fifo_level !== 3'd1) begin errors++; $display("FAIL single_push_level: got %0d expected 1", fifo_level); end
      start_run();
      run_frames(1, 1'b1);
   endtask

   task automatic test_random_stream();
      int n;
      n = $urandom_range(2, 4);
      push_burst(n);
      start_run();
      run_frames(n, 1'b1);
   endtask

   task automatic test_underflow();
      start_run();
      run_frames(3, 1'b1);
      checks++;
      if (underflow_count !== 16'd3) begin errors++; $display("FAIL underflow_count: got %0d expected 3", underflow_count); end
   endtask

   task automatic test_underflow_saturate();
      force dut.underflow_count = 16'hFFFF;
      tick();
      release dut.underflow_count;
      exp_uf = 16'hFFFF;
      start_run();
      run_frames(1, 1'b1);
      checks++;
      if (underflow_count !== 16'hFFFF) begin errors++; $display("FAIL underflow_saturate: got %h expected ffff", underflow_count); end
   endtask

   task automatic test_full_fifo();
      enable = 1'b0;
      push_burst(5);
      checks++;
      if (fifo_level !== 3'd4 || sample_ready !== 1'b0) begin
         errors++;
         $display("FAIL full_fifo: level=%0d ready=%b expected 4 0", fifo_level, sample_ready);
      end
   endtask

   task automatic test_reset_mid_frame();
      start_run();
      run_frames(2, 1'b0);
      tick_to(FRAME + 20 * SLOTC + H);
      checks++;
      if (bclk !== 1'b1 || lrclk !== 1'b1) begin errors++; $display("FAIL pre_reset_slot20: bclk=%b lrclk=%b expected 1 1", bclk, lrclk); end
      reset_n = 1'b0;
      #1;
      model_q.delete();
      exp_uf = '0;
      checks++;
      if (bclk !== 1'b0 || lrclk !== 1'b0 || dacdat !== 1'b0 || fifo_level !== 3'd0 ||
          sample_ready !== 1'b1 || underflow_count !== 16'd0) begin
         errors++;
         $display("FAIL async_reset: bclk=%b lrclk=%b dacdat=%b level=%0d ready=%b uf=%h",
                  bclk, lrclk, dacdat, fifo_level, sample_ready, underflow_count);
      end
      checks++;
      if (rx_q.size() - rx_base != 1 || rx_q[rx_base] !== exp_rx[0]) begin
         errors++;
         $display("FAIL rx_before_reset: count=%0d expected 1 frame %h", rx_q.size() - rx_base, exp_rx[0]);
      end
      repeat (3) tick();
      sample_left = 16'h8001; sample_right = 16'h7FFE; sample_valid = 1'b1;
      reset_n = 1'b1;
      tick();
      sample_valid = 1'b0;
      model_q.push_back(32'h80017FFE);
      begin_capture();
      run_frames(1, 1'b1);
   endtask

   initial begin
      test_reset();
      test_single_frame();
      test_random_stream();
      test_underflow();
      test_underflow_saturate();
      test_full_fifo();
      test_reset_mid_frame();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/i2s_transmitter.md
# i2s_transmitter

Serialises 16-bit stereo PCM samples into a Philips-format I2S stream on the audio codec pins (AUD_BCLK, AUD_DACLRCK, AUD_DACDAT). It sits at the output end of the audio path, where it is fed by the audio sample source through a valid/ready handshake. The bench's I2S receiver model consumes its output. A small internal FIFO absorbs producer jitter. The block generates the bit and word clocks itself from the system clock.

## Interface
- BCLK_HALF, 16: system clocks per BCLK half-period, ≥2. At 50 MHz this gives BCLK 1.5625 MHz and a 48.83 kHz frame rate.
- FIFO_DEPTH, 4: sample FIFO entries, power of two.
- clock  in  1  system clock; all logic is on the rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- enable  in  1  run request; sampled at frame boundaries.
- sample_valid  in  1  producer has a sample.
- sample_ready  out  1  FIFO not full; reset value 1.
- sample_left  in  16  signed left sample.
- sample_right  in  16  signed right sample.
- bclk  out  1  I2S bit clock; reset value 0.
- lrclk  out  1  word select, 0 = left; reset value 0.
- dacdat  out  1  serial data, MSB first; reset value 0.
- fifo_level  out  log2(FIFO_DEPTH)+1  occupied entries; reset value 0.
- underflow_count  out  16  frames sent with an empty FIFO, saturating; reset value 0.

## Operation
- FIFO:
  - Push when sample_valid && sample_ready. sample_ready = !full, derived from the registered level.
  - A push and a pop in the same cycle are both honoured.
  - When full, a push is refused even if a pop occurs in that cycle.
- State machine has two states:
  - IDLE: bclk, lrclk and dacdat are 0; the divider is cleared.
  - RUN: normal streaming.
- IDLE→RUN when enable=1. On entry: div=0, bclk=0, slot=0, lrclk=0, dacdat=0.
- Clock divider: div counts 0..BCLK_HALF-1. At BCLK_HALF-1 it wraps and bclk toggles.
- Falling bclk edges advance slot (0..31, wraps) and are the only points where lrclk and dacdat change.
- Slot rules, applied at the falling edge entering a slot:
  - Entering slot 1: pop the FIFO head into a 32-bit shift register as {left,right}. If the FIFO is empty, load 0 and increment underflow_count (saturate at 0xFFFF).
  - dacdat = sr[31], and sr shifts left by 1 on every subsequent falling edge.
  - lrclk = 1 for slots 16..31, 0 for slots 0..15. lrclk therefore leads the data MSB by one BCLK, per I2S.
  - Slots 1-16 carry left[15:0]; slots 17-31 carry right[15:1]; slot 0 of the next frame carries right[0].
- Stop: at the falling edge that would enter slot 1, if enable=0 the block goes to IDLE instead. No pop occurs, and the outputs go to 0 on that edge. Right[0] of the last frame has already been presented for a full slot.
- The FIFO accepts pushes in both states.
- Asserting reset_n low at any time forces every output to its reset value at once and empties the FIFO.

## Timing
- All outputs are registered and change only on the rising edge of clock.
- From the RUN entry edge:
  - first bclk rise after BCLK_HALF clocks;
  - first pop, lrclk=0 and left MSB on dacdat after 2·BCLK_HALF clocks.
- Frame period is 64·BCLK_HALF clocks. Each slot holds for 2·BCLK_HALF clocks, and the receiver samples at the bclk rise mid-slot.
- Pop-to-level: fifo_level decrements on the same edge as the slot-1 load.
- Push latency: an accepted sample is visible in fifo_level on the next cycle. It is eligible for the next slot-1 load if pushed at least one cycle before it.

## Structure
- audio_pkg holds:
  - the state enum (IDLE/RUN);
  - the I2S frame constants: 16 bits per channel, 32 slots;
  - the stereo sample struct {left,right}.
- A sub-module sample_fifo (synchronous FIFO: push/pop/full/empty/level, data width 32) is natural. The serialiser, divider and FSM stay in i2s_transmitter.

## Test plan
- Reset: hold reset_n=0 → bclk/lrclk/dacdat=0, sample_ready=1, fifo_level=0, underflow_count=0.
- Single frame, BCLK_HALF=2: push {0x1234,0xABCD}, then enable=1 → receiver reports left=0x1234, right=0xABCD. The first bclk rise occurs 2 clocks after RUN entry.
- Underflow: enable=1 with no pushes for 3 frames → dacdat stays 0 and underflow_count=3. Preload the count at 0xFFFF and it stays at 0xFFFF.
- Full FIFO: enable=0, push 5 samples back-to-back → 4 accepted, sample_ready=0 from the 4th accept, fifo_level=4.
- Stop mid-frame: drop enable at slot 10 → the frame completes including right[0] in slot 0. At the next boundary bclk/lrclk/dacdat go to 0, no pop occurs, and fifo_level is unchanged.
- Reset mid-frame: assert reset_n at slot 20 with 2 samples queued → outputs are 0 and fifo_level=0 immediately. After release with enable=1, streaming restarts from slot 0.
